ee354_ssd_ctrl: RTL and testbench

EE354_SSD_CTRL -- requirements
Module: ee354_ssd_ctrl

---
 rtl/ee354_ssd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ee354_ssd_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ee354_ssd_ctrl.sv
// Multiplexed seven-segment display controller: captures a binary value, shows it as
// hex or decimal (shift-add-3 conversion) with leading-zero blanking, overflow dashes and blink.
module ee354_ssd_ctrl #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned VAL_W     = 8,
  parameter int unsigned SCAN_DIV  = 18,
  parameter int unsigned BLINK_DIV = 25
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [VAL_W-1:0] Value,
  input  logic             Load,
  input  logic             Hex_Mode,
  input  logic             Blank_LZ,
  input  logic             Blink_En,
  output logic             Busy,
  output logic             Overflow,
  output logic [7:0]       An,
  output logic [7:0]       Cath
);

  localparam int unsigned BCD_D  = 9;
  localparam int unsigned BCD_W  = 4 * BCD_D;
  localparam int unsigned DISP_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned OVF_SH = 4 * N_DIGITS;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t             state;
  logic [VAL_W-1:0]   sh;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_nxt_c;
  logic [CNT_W-1:0]   cnt;
  logic [DISP_W-1:0]  disp;
  logic [DISP_W-1:0]  val_ext_c;
  logic [SCAN_DIV-1:0] presc;
  logic [2:0]         idx;
  logic               started;
  logic [BLINK_DIV:0] blink;
  logic [7:0]         blank_c;
  logic               seen_c;
  logic [3:0]         cur_dig_c;
  logic               scan_tick_c;

  // One shift-add-3 step: correct every BCD digit, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic in_bit);
    logic [BCD_W-1:0] t;
    t = b;
    for (int unsigned i = 0; i < BCD_D; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return BCD_W'({t, in_bit});
  endfunction

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 8'b00000011;
      4'h1: seg = 8'b10011111;
      4'h2: seg = 8'b00100101;
      4'h3: seg = 8'b00001101;
      4'h4: seg = 8'b10011001;
      4'h5: seg = 8'b01001001;
      4'h6: seg = 8'b01000001;
      4'h7: seg = 8'b00011111;
      4'h8: seg = 8'b00000001;
      4'h9: seg = 8'b00001001;
      4'hA: seg = 8'b00010001;
      4'hB: seg = 8'b11000001;
      4'hC: seg = 8'b01100011;
      4'hD: seg = 8'b10000101;
      4'hE: seg = 8'b01100001;
      default: seg = 8'b01110001;
    endcase
  endfunction

  assign bcd_nxt_c   = dd_step(bcd, sh[VAL_W-1]);
  assign val_ext_c   = DISP_W'(Value);
  assign scan_tick_c = &presc;
  assign cur_dig_c   = disp[{idx, 2'b00} +: 4];

  // A digit is blanked when it and every active digit above it are zero.
  always_comb begin
    blank_c = '0;
    seen_c  = 1'b0;
    for (int unsigned k = 7; k >= 1; k--) begin
      if (k < N_DIGITS) begin
        seen_c     = seen_c | (disp[4*k +: 4] != 4'h0);
        blank_c[k] = ~seen_c;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      Busy     <= 1'b0;
      Overflow <= 1'b0;
      sh       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      disp     <= '0;
      presc    <= '0;
      idx      <= '0;
      started  <= 1'b0;
      blink    <= '0;
      An       <= 8'hFF;
      Cath     <= 8'hFF;
    end else begin
      presc <= presc + 1'b1;
      blink <= blink + 1'b1;

      // Scan index: the first prescaler wrap only arms the display at digit 0.
      if (scan_tick_c) begin
        if (!started) begin
          started <= 1'b1;
        end else if (idx == 3'(N_DIGITS - 1)) begin
          idx <= '0;
        end else begin
          idx <= idx + 3'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (Load) begin
            if (Hex_Mode) begin
              disp     <= val_ext_c;
              Overflow <= (val_ext_c >> OVF_SH) != '0;
            end else begin
              sh    <= Value;
              bcd   <= '0;
              cnt   <= '0;
              Busy  <= 1'b1;
              state <= S_CONV;
            end
          end
        end
        default: begin
          bcd <= bcd_nxt_c;
          sh  <= sh << 1;
          cnt <= cnt + 5'd1;
          if (cnt == CNT_W'(VAL_W - 1)) begin
            disp     <= bcd_nxt_c[DISP_W-1:0];
            Overflow <= (bcd_nxt_c >> OVF_SH) != '0;
            Busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
      endcase

      if (!started || (Blink_En && blink[BLINK_DIV])) begin
        An <= 8'hFF;
      end else begin
        An <= ~(8'h01 << idx);
      end

      if (!started) begin
        Cath <= 8'hFF;
      end else if (Overflow) begin
        Cath <= 8'b11111101;
      end else if (Blank_LZ && blank_c[idx]) begin
        Cath <= 8'hFF;
      end else begin
        Cath <= seg(cur_dig_c);
      end
    end
  end

endmodule

// File: tb/tb_ee354_ssd_ctrl.sv
// Scoreboard bench for ee354_ssd_ctrl: three instances (4, 2 and 3 digits) share stimulus;
// expected displays are queued at load time and compared against the scanned segments.
module tb_ee354_ssd_ctrl;

  localparam int unsigned VW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [VW-1:0] value;
  logic          load, hex_mode, blank_lz, blink_en;
  logic          busy4, ovf4, busy2, ovf2, busy3, ovf3;
  logic [7:0]    an4, cath4, an2, cath2, an3, cath3;

  ee354_ssd_ctrl #(.N_DIGITS(4), .VAL_W(VW), .SCAN_DIV(2), .BLINK_DIV(6)) u_dut4 (
    .Clk(clk), .Reset_n(rst_n), .Value(value), .Load(load), .Hex_Mode(hex_mode),
    .Blank_LZ(blank_lz), .Blink_En(blink_en), .Busy(busy4), .Overflow(ovf4), .An(an4), .Cath(cath4));
  ee354_ssd_ctrl #(.N_DIGITS(2), .VAL_W(VW), .SCAN_DIV(2), .BLINK_DIV(6)) u_dut2 (
    .Clk(clk), .Reset_n(rst_n), .Value(value), .Load(load), .Hex_Mode(hex_mode),
    .Blank_LZ(blank_lz), .Blink_En(blink_en), .Busy(busy2), .Overflow(ovf2), .An(an2), .Cath(cath2));
  ee354_ssd_ctrl #(.N_DIGITS(3), .VAL_W(VW), .SCAN_DIV(2), .BLINK_DIV(6)) u_dut3 (
    .Clk(clk), .Reset_n(rst_n), .Value(value), .Load(load), .Hex_Mode(hex_mode),
    .Blank_LZ(blank_lz), .Blink_En(blink_en), .Busy(busy3), .Overflow(ovf3), .An(an3), .Cath(cath3));

  typedef struct {
    longint unsigned v;
    bit              hex;
    bit              blank;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_bad = 0;
  logic [7:0] seg_tab [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned ipow(input longint unsigned b, input int e);
    longint unsigned r = 1;
    for (int j = 0; j < e; j++) r = r * b;
    return r;
  endfunction

  function automatic bit exp_ovf(input exp_t e, input int n);
    return e.v >= ipow(e.hex ? 64'd16 : 64'd10, n);
  endfunction

  function automatic logic [7:0] exp_cath(input exp_t e, input int n, input int k);
    longint unsigned base = e.hex ? 64'd16 : 64'd10;
    longint unsigned pk   = ipow(base, k);
    if (exp_ovf(e, n)) return 8'b11111101;
    if (e.blank && k > 0 && e.v < pk) return 8'hFF;
    return seg_tab[4'((e.v / pk) % base)];
  endfunction

  function automatic int ndig(input int which);
    return (which == 0) ? 4 : (which == 1) ? 2 : 3;
  endfunction

  // Watch the scan until every active digit has been lit once; record its segments.
  task automatic read_disp(input int which, output logic [63:0] cv);
    int         n = ndig(which);
    logic [7:0] seen = '0;
    logic [7:0] a, c;
    cv = '1;
    for (int t = 0; t < 80 && seen != 8'((1 << n) - 1); t++) begin
      @(negedge clk);
      case (which)
        0:       begin a = an4; c = cath4; end
        1:       begin a = an2; c = cath2; end
        default: begin a = an3; c = cath3; end
      endcase
      for (int i = 0; i < n; i++) begin
        if (a == ~(8'h01 << i)) begin
          cv[8*i +: 8] = c;
          seen[i]      = 1'b1;
        end
      end
    end
    check($sformatf("scan_seen_n%0d", n), 32'(seen), 32'((1 << n) - 1));
  endtask

  task automatic compare_top(input string tag);
    exp_t        e;
    logic [63:0] cv;
    logic        ovf;
    int          n;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    for (int w = 0; w < 3; w++) begin
      n   = ndig(w);
      ovf = (w == 0) ? ovf4 : (w == 1) ? ovf2 : ovf3;
      check($sformatf("%s_n%0d_ovf", tag, n), 32'(ovf), 32'(exp_ovf(e, n)));
      read_disp(w, cv);
      for (int k = 0; k < n; k++)
        check($sformatf("%s_n%0d_d%0d", tag, n, k), 32'(cv[8*k +: 8]), 32'(exp_cath(e, n, k)));
    end
  endtask

  // Drive a one-cycle Load; returns 1 ns after the capturing edge.
  task automatic do_load(input longint unsigned v, input bit hex, input bit blank, input bit push);
    @(negedge clk);
    value    = VW'(v);
    hex_mode = hex;
    blank_lz = blank;
    load     = 1'b1;
    if (push) sb.push_back('{v, hex, blank});
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic count_busy(input bit inject, output int cnt);
    cnt = 0;
    for (int t = 0; t < 40; t++) begin
      if (inject && t == 3) begin
        value = 8'd37;
        load  = 1'b1;
      end
      if (inject && t == 4) load = 1'b0;
      if (!busy4) break;
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_dec(input longint unsigned v, input bit blank, input string tag);
    int cnt;
    do_load(v, 1'b0, blank, 1'b1);
    count_busy(1'b0, cnt);
    check({tag, "_busy_cycles"}, 32'(cnt), 32'd8);
    repeat (2) @(negedge clk);
    compare_top(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int blank_cnt;
    seg_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    rst_n = 1'b1; value = '0; load = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_ovf",  32'(ovf4),  32'd0);
    check("rst_an",   32'(an4),   32'hFF);
    check("rst_cath", 32'(cath4), 32'hFF);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // First light on digit 0 after 2^SCAN_DIV+1 clocks, then 4 clocks per digit.
    for (int c = 1; c <= 28; c++) begin
      @(posedge clk);
      #1;
      if (c == 4) check("an_before_start", 32'(an4), 32'hFF);
      if (c == 5) check("an_first_digit0", 32'(an4), 32'hFE);
      if (c >= 5) check($sformatf("scan3_c%0d", c), 32'(an3), 32'(8'(~(8'h01 << (((c - 5) / 4) % 3)))));
    end

    run_dec(225, 1'b0, "dec225");
    run_dec(225, 1'b1, "dec225_blank");
    run_dec(150, 1'b0, "dec150");

    do_load(64'hAB, 1'b1, 1'b0, 1'b1);
    check("hex_busy_edge", 32'(busy4), 32'd0);
    check("hex_ovf2_next_edge", 32'(ovf2), 32'd0);
    count_busy(1'b0, cnt);
    check("hex_busy_cycles", 32'(cnt), 32'd0);
    repeat (2) @(negedge clk);
    compare_top("hexAB");

    run_dec(99, 1'b0, "dec99");

    do_load(225, 1'b0, 1'b0, 1'b1);
    count_busy(1'b1, cnt);
    check("second_load_busy_cycles", 32'(cnt), 32'd8);
    repeat (4) @(negedge clk);
    check("second_load_idle", 32'(busy4), 32'd0);
    compare_top("second_load");

    // Reset mid-conversion: outputs clear without a clock edge, result is discarded.
    do_load(150, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    check("busy_before_reset", 32'(busy4), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    sb.push_back('{64'd0, 1'b0, 1'b0});
    #1;
    check("async_rst_busy", 32'(busy4), 32'd0);
    check("async_rst_an",   32'(an4),   32'hFF);
    check("async_rst_cath", 32'(cath4), 32'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (busy4) cnt++;
    end
    check("post_rst_busy", 32'(cnt), 32'd0);
    compare_top("post_rst");

    blink_en  = 1'b1;
    blank_cnt = 0;
    repeat (4) @(posedge clk);
    for (int t = 0; t < 128; t++) begin
      @(posedge clk);
      #1;
      if (an4 == 8'hFF) blank_cnt++;
    end
    check("blink_dark_clocks", 32'(blank_cnt), 32'd64);
    blink_en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
